// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider; master is the operand source
// and result consumer, slave is the divider.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock: result WIDTH cycles after accept
// (divide-by-zero: 1 cycle); result is held stable under out_ready=0, no new operands until consumed.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        shifted = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvs_d   = bus.divisor;
                    q_d     = bus.dividend;
                    p_d     = '0;
                    dz_d    = (bus.divisor == '0);
                    cnt_d   = (bus.divisor == '0) ? '0 : CW'(WIDTH - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                // A zero divisor spends its single CALC cycle forming the saturated result.
                if (dz_q) begin
                    q_d     = '1;
                    p_d     = {1'b0, q_q};
                    state_d = DONE;
                end else begin
                    p_d = trial[WIDTH] ? shifted : trial;
                    q_d = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = (state_q == DONE) ? q_q : '0;
    assign bus.remainder   = (state_q == DONE) ? p_q[WIDTH-1:0] : '0;
    assign bus.div_by_zero = (state_q == DONE) && dz_q;
endmodule
